y86_seq_controller: RTL

- Parametrised multi-cycle sequencer for the Y86-64 SEQ core.
- Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, one state per stage.
- Adds behaviour the single-edge sequential core lacks:
  - req/ack handshakes to instruction and data memory, with timeout;
  - Y86 status tracking (AOK/HLT/ADR/INS) and a sticky HALT state;
  - PC ownership and next-PC selection;
  - a retired-instruction counter.
- Sits above the stage datapath blocks and drives their per-stage enables.

---
 rtl/y86_seq_controller_if.sv | 28 ++
 rtl/y86_seq_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_controller_if.sv
// Memory handshake bundle between the Y86 SEQ sequencer and the instruction/data memories.
// The master side issues requests; the slave side answers with ack and a fault flag.
interface y86_seq_controller_if;
    logic imem_req;
    logic imem_ack;
    logic imem_error;
    logic dmem_req;
    logic dmem_ack;
    logic dmem_error;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ack,
        input  imem_error,
        input  dmem_ack,
        input  dmem_error
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ack,
        output imem_error,
        output dmem_ack,
        output dmem_error
    );
endinterface

// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ core: walks each instruction through its stages,
// owns the PC, tracks Y86 status, bounds memory waits and counts retired instructions.
module y86_seq_controller #(
    parameter int unsigned       ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       MEM_TIMEOUT = 15,
    parameter int unsigned       CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    y86_seq_controller_if.master mem,
    input  logic [3:0]           icode,
    input  logic                 cnd,
    input  logic                 instr_valid,
    input  logic [ADDR_W-1:0]    valC,
    input  logic [ADDR_W-1:0]    valP,
    input  logic [ADDR_W-1:0]    valM,
    output logic [ADDR_W-1:0]    pc,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 execute_en,
    output logic                 mem_en,
    output logic                 wb_en,
    output logic                 pc_en,
    output logic                 cc_en,
    output logic [2:0]           stat,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired
);

    localparam int unsigned TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        PCUPD,
        HALT
    } stateT;

    stateT             state, stateNext;
    logic [ADDR_W-1:0] pcNext;
    logic [2:0]        statNext;
    logic [CNT_W-1:0]  retiredNext;
    logic [TO_W-1:0]   toCnt, toCntNext;
    logic              imemReq, dmemReq;
    logic              memOp;

    assign memOp = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                   (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);

    assign mem.imem_req = imemReq;
    assign mem.dmem_req = dmemReq;
    assign halted       = (state == HALT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            stat    <= STAT_AOK;
            retired <= '0;
            toCnt   <= '0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            stat    <= statNext;
            retired <= retiredNext;
            toCnt   <= toCntNext;
        end
    end

    // The timeout counter only runs while a request waits; reaching TO_LAST on a
    // no-ack cycle means the request has been outstanding MEM_TIMEOUT cycles.
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        statNext    = stat;
        retiredNext = retired;
        toCntNext   = toCnt;
        imemReq     = 1'b0;
        dmemReq     = 1'b0;
        fetch_en    = 1'b0;
        decode_en   = 1'b0;
        execute_en  = 1'b0;
        mem_en      = 1'b0;
        wb_en       = 1'b0;
        pc_en       = 1'b0;
        cc_en       = 1'b0;

        case (state)
            FETCH: begin
                fetch_en = 1'b1;
                imemReq  = 1'b1;
                if (mem.imem_ack) begin
                    if (mem.imem_error) begin
                        statNext  = STAT_ADR;
                        stateNext = HALT;
                    end else if (!instr_valid) begin
                        statNext  = STAT_INS;
                        stateNext = HALT;
                    end else begin
                        stateNext = DECODE;
                    end
                end else if (toCnt == TO_LAST) begin
                    statNext  = STAT_ADR;
                    stateNext = HALT;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                end
            end

            DECODE: begin
                decode_en = 1'b1;
                stateNext = EXECUTE;
            end

            EXECUTE: begin
                execute_en = 1'b1;
                cc_en      = (icode == I_OPQ);
                toCntNext  = '0;
                stateNext  = MEMORY;
            end

            MEMORY: begin
                mem_en = 1'b1;
                if (memOp) begin
                    dmemReq = 1'b1;
                    if (mem.dmem_ack) begin
                        if (mem.dmem_error) begin
                            statNext  = STAT_ADR;
                            stateNext = HALT;
                        end else begin
                            stateNext = WRITEBACK;
                        end
                    end else if (toCnt == TO_LAST) begin
                        statNext  = STAT_ADR;
                        stateNext = HALT;
                    end else begin
                        toCntNext = toCnt + TO_W'(1);
                    end
                end else begin
                    stateNext = WRITEBACK;
                end
            end

            WRITEBACK: begin
                wb_en     = 1'b1;
                stateNext = PCUPD;
            end

            // A halt instruction stops here without retiring, leaving pc on itself.
            PCUPD: begin
                pc_en = 1'b1;
                if (icode == I_HALT) begin
                    statNext  = STAT_HLT;
                    stateNext = HALT;
                end else begin
                    if ((icode == I_CALL) || ((icode == I_JXX) && cnd)) begin
                        pcNext = valC;
                    end else if (icode == I_RET) begin
                        pcNext = valM;
                    end else begin
                        pcNext = valP;
                    end
                    retiredNext = retired + CNT_W'(1);
                    toCntNext   = '0;
                    stateNext   = FETCH;
                end
            end

            HALT: begin
                stateNext = HALT;
            end

            default: begin
                stateNext = HALT;
            end
        endcase
    end

endmodule
